// File: rtl/spectrogram_bit_packer_pkg.sv
// rtl/spectrogram_bit_packer_pkg.sv - shared STFT chain constants and helpers
package spectrogram_bit_packer_pkg;

  localparam int STFT_CNT_W     = 17;
  localparam int DEF_PW         = 32;
  localparam int DEF_FRAME_BITS = 16384;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spectrogram_bit_packer_fifo.sv
// rtl/spectrogram_bit_packer_fifo.sv - synchronous word FIFO with fall-through head
module packer_fifo
  import spectrogram_bit_packer_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         iCLK,
  input  logic         iRSTn,
  input  logic         iCLR,
  input  logic         iPush,
  input  logic [W-1:0] iPushData,
  input  logic         iPop,
  output logic         oFull,
  output logic         oEmpty,
  output logic [W-1:0] oHead
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wrPtr;
  logic [AW:0]  rdPtr;
  logic         doPush;
  logic         doPop;

  // Extra pointer bit distinguishes full from empty when indices coincide.
  assign oEmpty = (wrPtr == rdPtr);
  assign oFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = !iCLR && iPop && !oEmpty;
  assign doPush = !iCLR && iPush && (!oFull || doPop);
  assign oHead  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (iCLR) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= iPushData;
  end

endmodule

// File: rtl/spectrogram_bit_packer.sv
// rtl/spectrogram_bit_packer.sv - packs 1-bit bins into PW-bit words with frame tags
module spectrogram_bit_packer
  import spectrogram_bit_packer_pkg::*;
#(
  parameter int PW         = DEF_PW,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CNT_W      = STFT_CNT_W,
  parameter int DEPTH      = 4
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iCLR,
  input  logic          iEN,
  input  logic          iDATA,
  input  logic          iRDY,
  output logic          oEN,
  output logic [PW-1:0] oDATA,
  output logic          oLAST,
  output logic          oOVF
);

  localparam int BW = clog2(PW);

  logic [BW-1:0]    bitCnt;
  logic [CNT_W-1:0] frameCnt;
  logic [PW-1:0]    shiftReg;
  logic [PW-1:0]    nextWord;
  logic             lastBin;
  logic             wordDone;
  logic             full;
  logic             empty;
  logic [PW:0]      head;
  logic             pop;
  logic             push;
  logic             drop;

  assign lastBin  = (frameCnt == CNT_W'(FRAME_BITS - 1));
  assign wordDone = iEN && ((bitCnt == BW'(PW - 1)) || lastBin);
  assign nextWord = shiftReg | (PW'(iDATA) << bitCnt);

  assign pop  = !iCLR && !empty && iRDY;
  assign push = !iCLR && wordDone && (!full || pop);
  assign drop = wordDone && full && !pop;

  assign oEN   = !empty;
  assign oDATA = empty ? '0 : head[PW-1:0];
  assign oLAST = !empty && head[PW];

  // Shift register restarts at zero on every completed word so partial words carry no stale bits.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      bitCnt   <= '0;
      frameCnt <= '0;
      shiftReg <= '0;
      oOVF     <= 1'b0;
    end else if (iCLR) begin
      bitCnt   <= '0;
      frameCnt <= '0;
      shiftReg <= '0;
      oOVF     <= 1'b0;
    end else begin
      if (iEN) begin
        if (wordDone) begin
          bitCnt   <= '0;
          shiftReg <= '0;
        end else begin
          bitCnt   <= bitCnt + BW'(1);
          shiftReg <= nextWord;
        end
        frameCnt <= lastBin ? '0 : frameCnt + CNT_W'(1);
      end
      if (drop) oOVF <= 1'b1;
    end
  end

  packer_fifo #(
    .W     (PW + 1),
    .DEPTH (DEPTH)
  ) uFifo (
    .iCLK      (iCLK),
    .iRSTn     (iRSTn),
    .iCLR      (iCLR),
    .iPush     (push),
    .iPushData ({lastBin, nextWord}),
    .iPop      (pop),
    .oFull     (full),
    .oEmpty    (empty),
    .oHead     (head)
  );

endmodule
